// File: rtl/csa4.sv
`default_nettype none
// ============================================================================
//  Module   : csa4
//  Summary  : 4-bit carry-select adder, two 2-bit blocks, registered result.
//  Revision : 1.0  initial release
// ============================================================================
module csa4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       in_valid,
    output logic [3:0] sum,
    output logic       cout,
    output logic       out_valid
);

    // The adder has no external carry-in, so the low block always selects cin=0.
    localparam logic c_lo_sel = 1'b0;

    // Full adder primitive, returns {carry_out, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
        return {co, s};
    endfunction

    function automatic logic mux2(input logic sel, input logic d0, input logic d1);
        return sel ? d1 : d0;
    endfunction

    logic [3:0] sum0;
    logic [3:0] sum1;
    logic       c1;
    logic       cout0_0;
    logic       cout0_1;
    logic       cout1_0;
    logic       cout1_1;

    logic       w_k0_lo;
    logic       w_k1_lo;
    logic       w_k0_hi;
    logic       w_k1_hi;
    logic [3:0] sum_c;
    logic       cout_c;

    // Low block: two-bit ripples for cin=0 and cin=1.
    assign {w_k0_lo, sum0[0]} = fa(a[0], b[0], 1'b0);
    assign {cout0_0, sum0[1]} = fa(a[1], b[1], w_k0_lo);
    assign {w_k1_lo, sum1[0]} = fa(a[0], b[0], 1'b1);
    assign {cout0_1, sum1[1]} = fa(a[1], b[1], w_k1_lo);

    // High block: two-bit ripples for cin=0 and cin=1.
    assign {w_k0_hi, sum0[2]} = fa(a[2], b[2], 1'b0);
    assign {cout1_0, sum0[3]} = fa(a[3], b[3], w_k0_hi);
    assign {w_k1_hi, sum1[2]} = fa(a[2], b[2], 1'b1);
    assign {cout1_1, sum1[3]} = fa(a[3], b[3], w_k1_hi);

    generate
        for (genvar i = 0; i < 2; i++) begin : g_lo_sel
            assign sum_c[i] = mux2(c_lo_sel, sum0[i], sum1[i]);
        end
    endgenerate

    assign c1 = mux2(c_lo_sel, cout0_0, cout0_1);

    generate
        for (genvar i = 2; i < 4; i++) begin : g_hi_sel
            assign sum_c[i] = mux2(c1, sum0[i], sum1[i]);
        end
    endgenerate

    assign cout_c = mux2(c1, cout1_0, cout1_1);

    // Output register stage.
    logic [3:0] sum_d;
    logic [3:0] sum_q;
    logic       cout_d;
    logic       cout_q;
    logic       out_valid_d;
    logic       out_valid_q;

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum_c;
            cout_d = cout_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= 4'd0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_csa4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa4
//  Summary  : Self-checking bench for csa4: directed table, sweep, scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csa4;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [3:0] sum;
    logic       cout;
    logic       out_valid;

    int errors = 0;
    int checks = 0;

    logic [4:0] sb[$];
    logic [3:0] held_sum;
    logic       held_cout;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_sum;
        logic       exp_cout;
        logic       exp_c1;
    } vec_t;

    vec_t tbl[9];

    csa4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (a=%0d b=%0d t=%0t)", name, act, exp, a, b, $time);
        end
    endtask

    // Drive one cycle starting at a falling edge; optionally pulse reset mid-cycle.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tv, input logic pulse);
        logic [2:0] lo0, lo1, hi0, hi1;
        logic [4:0] exp;
        a        = ta;
        b        = tb;
        in_valid = tv;
        lo0 = {1'b0, ta[1:0]} + {1'b0, tb[1:0]};
        lo1 = lo0 + 3'd1;
        hi0 = {1'b0, ta[3:2]} + {1'b0, tb[3:2]};
        hi1 = hi0 + 3'd1;
        if (tv) sb.push_back({1'b0, ta} + {1'b0, tb});
        #1;
        check("sum0",    {4'd0, dut.sum0},   {4'd0, hi0[1:0], lo0[1:0]});
        check("sum1",    {4'd0, dut.sum1},   {4'd0, hi1[1:0], lo1[1:0]});
        check("cout0_0", {7'd0, dut.cout0_0}, {7'd0, lo0[2]});
        check("cout0_1", {7'd0, dut.cout0_1}, {7'd0, lo1[2]});
        check("cout1_0", {7'd0, dut.cout1_0}, {7'd0, hi0[2]});
        check("cout1_1", {7'd0, dut.cout1_1}, {7'd0, hi1[2]});
        check("c1",      {7'd0, dut.c1},      {7'd0, lo0[2]});
        check("sum_c_lo", {6'd0, dut.sum_c[1:0]}, {6'd0, dut.sum0[1:0]});
        if (pulse) begin
            #1 rst_n = 1'b0;
            #1;
            check("rst_mid_sum",   {4'd0, sum},       8'd0);
            check("rst_mid_cout",  {7'd0, cout},      8'd0);
            check("rst_mid_valid", {7'd0, out_valid}, 8'd0);
            held_sum  = 4'd0;
            held_cout = 1'b0;
            #1 rst_n = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (tv) begin
            if (sb.size() == 0) begin
                check("sb_empty", 8'd1, 8'd0);
            end else begin
                exp = sb.pop_front();
                check("out_sum",   {4'd0, sum},       {4'd0, exp[3:0]});
                check("out_cout",  {7'd0, cout},      {7'd0, exp[4]});
                check("out_valid", {7'd0, out_valid}, 8'd1);
                held_sum  = exp[3:0];
                held_cout = exp[4];
            end
        end else begin
            check("hold_sum",   {4'd0, sum},       {4'd0, held_sum});
            check("hold_cout",  {7'd0, cout},      {7'd0, held_cout});
            check("hold_valid", {7'd0, out_valid}, 8'd0);
        end
    endtask

    initial begin
        tbl[0] = '{4'd3,  4'd1,  4'd4,  1'b0, 1'b1};
        tbl[1] = '{4'd4,  4'd8,  4'd12, 1'b0, 1'b0};
        tbl[2] = '{4'd15, 4'd15, 4'd14, 1'b1, 1'b1};
        tbl[3] = '{4'd9,  4'd9,  4'd2,  1'b1, 1'b0};
        tbl[4] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
        tbl[5] = '{4'd8,  4'd8,  4'd0,  1'b1, 1'b0};
        tbl[6] = '{4'd7,  4'd9,  4'd0,  1'b1, 1'b1};
        tbl[7] = '{4'd10, 4'd5,  4'd15, 1'b0, 1'b0};
        tbl[8] = '{4'd6,  4'd10, 4'd0,  1'b1, 1'b1};

        rst_n     = 1'b1;
        a         = 4'd15;
        b         = 4'd15;
        in_valid  = 1'b1;
        held_sum  = 4'd0;
        held_cout = 1'b0;

        // Reset with no clock edge yet, then hold through several edges.
        #1 rst_n = 1'b0;
        #2;
        check("rst_sum",   {4'd0, sum},       8'd0);
        check("rst_cout",  {7'd0, cout},      8'd0);
        check("rst_valid", {7'd0, out_valid}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_sum",   {4'd0, sum},       8'd0);
        check("rst_hold_valid", {7'd0, out_valid}, 8'd0);
        rst_n = 1'b1;
        step(4'd15, 4'd15, 1'b1, 1'b0);
        check("first_sum",  {4'd0, sum},  8'd14);
        check("first_cout", {7'd0, cout}, 8'd1);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].a, tbl[i].b, 1'b1, 1'b0);
            check("tbl_c1",   {7'd0, dut.c1}, {7'd0, tbl[i].exp_c1});
            check("tbl_sum",  {4'd0, sum},    {4'd0, tbl[i].exp_sum});
            check("tbl_cout", {7'd0, cout},   {7'd0, tbl[i].exp_cout});
        end

        // Hold: capture 9+9 then idle with different operands.
        step(4'd9, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'd1, 4'd1, 1'b0, 1'b0);
            check("idle_sum",  {4'd0, sum},  8'd2);
            check("idle_cout", {7'd0, cout}, 8'd1);
        end

        // Exhaustive back-to-back sweep with a mid-stream reset pulse.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            step(v[7:4], v[3:0], 1'b1, (i == 100) ? 1'b1 : 1'b0);
        end

        // Idle after the sweep: last result must hold.
        step(4'd0, 4'd0, 1'b0, 1'b0);
        check("sb_drained", 8'(sb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csa4.md
# csa4

4-bit carry-select adder with a registered result stage. Operands are summed combinationally in two 2-bit blocks. Each block precomputes results for carry-in 0 and carry-in 1, and the true carry selects between them. The result is captured on the clock edge with a valid flag. It serves as a small arithmetic leaf cell and as the reference carry-select structure for wider adders built from it.

## Interface
- No parameters; width fixed at 4 bits (two 2-bit blocks).
- clk  input  1  rising-edge clock for the output register stage.
- rst_n  input  1  asynchronous active-low reset; clears all registered outputs.
- a  input  4  unsigned operand A.
- b  input  4  unsigned operand B.
- in_valid  input  1  qualifies a/b; result is captured only when high.
- sum  output  4  registered a+b, modulo 16.
- cout  output  1  registered carry out of bit 3.
- out_valid  output  1  registered copy of in_valid.

## Operation
- Internal combinational nets are required with exactly these names, so they can be probed hierarchically:
  - sum0[3:0], sum1[3:0].
  - c1.
  - cout0_0, cout0_1.
  - cout1_0, cout1_1.
- Low block, bits 1:0, ripple of two full adders, computed twice:
  - cin=0 path: {cout0_0, sum0[1:0]} = a[1:0] + b[1:0].
  - cin=1 path: {cout0_1, sum1[1:0]} = a[1:0] + b[1:0] + 1.
  - Low mux select is tied to 0 (adder has no external carry-in).
  - Low sum = sum0[1:0]; c1 = cout0_0.
- High block, bits 3:2, computed twice:
  - cin=0 path: {cout1_0, sum0[3:2]} = a[3:2] + b[3:2].
  - cin=1 path: {cout1_1, sum1[3:2]} = a[3:2] + b[3:2] + 1.
  - Select on c1: c1=0 picks sum0[3:2] and cout1_0; c1=1 picks sum1[3:2] and cout1_1.
- Combinational result is {cout_c, sum_c} = a + b as a 5-bit unsigned value, never truncated.
- Build from full-adder and 2:1 mux primitives. No behavioural "+" on the full 4-bit width.
- Register stage:
  - On clk rise with in_valid=1: sum<=sum_c, cout<=cout_c, out_valid<=1.
  - With in_valid=0: out_valid<=0; sum and cout hold their previous values.
- Internal nets are purely combinational functions of a and b. They do not depend on in_valid, clk or rst_n, and are never X once a and b are known.

## Timing
- Latency is one clock: a result presented with in_valid is visible on sum/cout/out_valid after the next rising edge.
- Throughput is one operation per cycle; back-to-back in_valid is supported with no bubbles.
- Reset:
  - rst_n low forces sum=0, cout=0, out_valid=0 immediately, with no clock needed.
  - Outputs stay cleared while rst_n is low.
  - The first capture happens on the first rising edge after rst_n deasserts.
- Reset asserted mid-stream: any in-flight result is discarded and out_valid drops at once.
- The combinational path (a/b to internal nets) settles within one clock period. It has no clock dependency and may be checked after a short settle delay.

## Test plan
- Reset: assert rst_n=0 with a=15, b=15, in_valid=1 -> sum=0, cout=0, out_valid=0 with no clock edge. After release and one edge -> sum=14, cout=1, out_valid=1.
- Low carry into high block: a=3, b=1 -> c1=1, cout0_0=1, sum0[1:0]=00, sum1[1:0]=01. After the edge, sum=4 and cout=0 (high mux took sum1[3:2]=01).
- No low carry: a=4, b=8 -> c1=0, sum0[3:2]=11, sum1[3:2]=00, cout1_1=1. After the edge, sum=12 and cout=0.
- Exhaustive sweep of all 256 a/b pairs with in_valid=1 every cycle:
  - Each output equals the previous cycle's a+b.
  - Internal nets match the 2-bit cin=0/cin=1 sums.
  - sum[1:0] of the combinational result equals sum0[1:0].
- Hold: capture a=9, b=9 (sum=2, cout=1), then drive in_valid=0 with a=1, b=1 for 3 cycles -> sum stays 2, cout stays 1, out_valid=0.
- Mid-stream reset: pulse rst_n low between two clock edges during back-to-back traffic -> outputs clear asynchronously; valid results resume one edge after release.
